// File: rtl/approx_mul_err_sweep.sv
// rtl/approx_mul_err_sweep.sv - exhaustive operand sweep and error accumulator for an approximate multiplier
module approx_mul_err_sweep #(
  parameter int N       = 4,
  parameter int DUT_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N-1:0]     op_a,
  output logic [N-1:0]     op_b,
  input  logic [2*N-1:0]   approx_prod,
  output logic             busy,
  output logic             done,
  output logic             sample_vld,
  output logic [2*N:0]     err_count,
  output logic [4*N-1:0]   sum_ed,
  output logic [2*N-1:0]   max_ed
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  localparam int CW = (DUT_LAT < 2) ? 1 : $clog2(DUT_LAT + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    drain_cnt;
  logic             accept;
  logic             last_pair;
  logic [2*N-1:0]   exact_now;
  logic [2*N-1:0]   exact_cmp;
  logic [2*N-1:0]   ed;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_pair = (&op_a) && (&op_b);
  assign exact_now = (2*N)'(op_a) * (2*N)'(op_b);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SWEEP;
      end
      SWEEP: begin
        busy = 1'b1;
        if (last_pair) begin
          if (DUT_LAT == 0) state_nxt = DONE;
          else              state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = SWEEP;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Drain countdown: DUT_LAT cycles after the final pair leaves the operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt <= '0;
    end else if ((state == SWEEP) && last_pair) begin
      drain_cnt <= CW'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);
    end else if ((state == DRAIN) && (drain_cnt != '0)) begin
      drain_cnt <= drain_cnt - 1'b1;
    end
  end

  // Operand walk: {op_a, op_b} counts up so op_b is the inner loop; holds after the last pair
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
    end else if (accept) begin
      op_a <= '0;
      op_b <= '0;
    end else if ((state == SWEEP) && !last_pair) begin
      {op_a, op_b} <= {op_a, op_b} + (2*N)'(1);
    end
  end

  generate
    if (DUT_LAT == 0) begin : g_comb
      assign sample_vld = (state == SWEEP);
      assign exact_cmp  = exact_now;
    end else begin : g_pipe
      logic [DUT_LAT-1:0] vld_sr;
      logic [2*N-1:0]     prod_sr [DUT_LAT];

      // Delay line aligning the exact product with the multiplier's output
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_sr <= '0;
          for (int i = 0; i < DUT_LAT; i++) prod_sr[i] <= '0;
        end else begin
          vld_sr[0]  <= (state == SWEEP);
          prod_sr[0] <= exact_now;
          for (int i = 1; i < DUT_LAT; i++) begin
            vld_sr[i]  <= vld_sr[i-1];
            prod_sr[i] <= prod_sr[i-1];
          end
        end
      end

      assign sample_vld = vld_sr[DUT_LAT-1];
      assign exact_cmp  = prod_sr[DUT_LAT-1];
    end
  endgenerate

  // Absolute error distance, unsigned over the full product width
  always_comb begin
    ed = '0;
    if (approx_prod >= exact_cmp) ed = approx_prod - exact_cmp;
    else                          ed = exact_cmp - approx_prod;
  end

  // Accumulators: cleared on an accepted start, updated on every compared sample
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
    end else if (sample_vld) begin
      err_count <= err_count + (2*N+1)'(ed != '0);
      sum_ed    <= sum_ed + (4*N)'(ed);
      if (ed > max_ed) max_ed <= ed;
    end
  end

endmodule

// File: tb/tb_approx_mul_err_sweep.sv
// tb/tb_approx_mul_err_sweep.sv - self-checking bench for approx_mul_err_sweep
module tb_approx_mul_err_sweep;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start2;
  logic [1:0] mode;
  logic       sel;
  logic [7:0] tbl [256];

  logic [3:0] op_a0, op_b0, op_a2, op_b2;
  logic [7:0] prod0, f2, d1 = 8'd0, d2 = 8'd0;
  logic       busy0, done0, vld0, busy2, done2, vld2;
  logic [8:0] err0, err2;
  logic [15:0] sum0, sum2;
  logic [7:0] max0, max2;

  logic [3:0] v_op_a, v_op_b;
  logic       v_busy, v_done, v_vld;
  logic [8:0] v_err;
  logic [15:0] v_sum;
  logic [7:0] v_max;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  approx_mul_err_sweep #(.N(4), .DUT_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .op_a(op_a0), .op_b(op_b0),
    .approx_prod(prod0), .busy(busy0), .done(done0), .sample_vld(vld0),
    .err_count(err0), .sum_ed(sum0), .max_ed(max0)
  );

  approx_mul_err_sweep #(.N(4), .DUT_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .op_a(op_a2), .op_b(op_b2),
    .approx_prod(d2), .busy(busy2), .done(done2), .sample_vld(vld2),
    .err_count(err2), .sum_ed(sum2), .max_ed(max2)
  );

  // Multiplier under test: 0 exact, 1 zero, 2 LSB cleared, 3 random table
  assign prod0 = (mode == 2'd0) ? 8'(op_a0) * 8'(op_b0) :
                 (mode == 2'd1) ? 8'd0 :
                 (mode == 2'd2) ? ((8'(op_a0) * 8'(op_b0)) & 8'hFE) :
                                  tbl[{op_a0, op_b0}];
  assign f2    = (mode == 2'd0) ? 8'(op_a2) * 8'(op_b2) :
                 (mode == 2'd1) ? 8'd0 :
                 (mode == 2'd2) ? ((8'(op_a2) * 8'(op_b2)) & 8'hFE) :
                                  tbl[{op_a2, op_b2}];

  // Two-stage registered multiplier for the DUT_LAT=2 instance
  always @(posedge clk) begin
    d1 <= f2;
    d2 <= d1;
  end

  // Observation mux over the two instances
  always_comb begin
    if (sel) begin
      v_op_a = op_a2; v_op_b = op_b2; v_busy = busy2; v_done = done2; v_vld = vld2;
      v_err = err2; v_sum = sum2; v_max = max2;
    end else begin
      v_op_a = op_a0; v_op_b = op_b0; v_busy = busy0; v_done = done0; v_vld = vld0;
      v_err = err0; v_sum = sum0; v_max = max0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start2 = v;
    else     start0 = v;
  endtask

  function automatic int ref_prod(input int m, input int a, input int b);
    int ex;
    ex = a * b;
    case (m)
      0:       return ex;
      1:       return 0;
      2:       return ex - (ex % 2);
      default: return int'(tbl[a*16 + b]);
    endcase
  endfunction

  task automatic do_sweep(input string name, input bit pre, input int lat,
                          input int glitch_k, input bit restart);
    int e_err, e_sum, e_max, p, ed;
    int done_cyc, nsamp, first, order_bad;
    logic busy_at_done;
    e_err = 0; e_sum = 0; e_max = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        p  = ref_prod(int'(mode), a, b);
        ed = (p > a*b) ? p - a*b : a*b - p;
        if (ed != 0) e_err++;
        e_sum += ed;
        if (ed > e_max) e_max = ed;
      end
    end
    done_cyc = -1; nsamp = 0; first = -1; order_bad = 0; busy_at_done = 1'bx;
    if (!pre) begin
      @(negedge clk);
      set_start(1'b1);
      @(posedge clk);
      #1;
      set_start(1'b0);
    end
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (glitch_k >= 0 && i == glitch_k + 1) set_start(1'b1);
      else                                    set_start(1'b0);
      if (i == 1) check({name, " acc_clear"}, {39'd0, v_err, v_sum, v_max}, 64'd0);
      if (i <= 256 && (v_op_a !== 4'((i-1) / 16) || v_op_b !== 4'((i-1) % 16))) order_bad++;
      if (v_vld === 1'b1) begin
        nsamp++;
        if (first < 0) first = i;
      end
      if (v_done === 1'b1) begin
        done_cyc = i;
        busy_at_done = v_busy;
        break;
      end
    end
    check({name, " done_cycle"}, 64'(done_cyc), 64'(257 + lat));
    check({name, " busy_at_done"}, 64'(busy_at_done), 64'd0);
    check({name, " op_order"}, 64'(order_bad), 64'd0);
    check({name, " n_samples"}, 64'(nsamp), 64'd256);
    check({name, " first_sample"}, 64'(first), 64'(1 + lat));
    check({name, " err_count"}, 64'(v_err), 64'(e_err));
    check({name, " sum_ed"}, 64'(v_sum), 64'(e_sum));
    check({name, " max_ed"}, 64'(v_max), 64'(e_max));
    if (restart) begin
      set_start(1'b1);
      @(posedge clk);
      #1;
      set_start(1'b0);
    end else begin
      @(negedge clk);
      check({name, " done_pulse_end"}, {62'd0, v_done, v_busy}, 64'd0);
      check({name, " hold"}, {32'd0, v_err, v_sum[6:0], v_max, v_op_a, v_op_b},
            {32'd0, 9'(e_err), 7'(e_sum), 8'(e_max), 8'hFF});
      check({name, " hold_sum"}, 64'(v_sum), 64'(e_sum));
    end
  endtask

  initial begin
    int seen_done;
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0; sel = 1'b0; mode = 2'd0;
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 2) == 0) tbl[i] = 8'($urandom);
      else                           tbl[i] = 8'((i / 16) * (i % 16));
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_dut0", {29'd0, op_a0, op_b0, busy0, done0, vld0, err0, sum0, max0}, 64'd0);
    check("reset_dut2", {29'd0, op_a2, op_b2, busy2, done2, vld2, err2, sum2, max2}, 64'd0);
    rst = 1'b0;

    mode = 2'd0; do_sweep("exact_lat0", 1'b0, 0, -1, 1'b0);
    mode = 2'd1; do_sweep("zero_lat0", 1'b0, 0, -1, 1'b0);
    check("zero_lat0 spec_err", 64'(err0), 64'd225);
    check("zero_lat0 spec_sum", 64'(sum0), 64'd14400);
    mode = 2'd2; do_sweep("lsb_lat0", 1'b0, 0, -1, 1'b0);
    check("lsb_lat0 spec", {39'd0, err0, sum0, max0}, {39'd0, 9'd64, 16'd64, 8'd1});
    mode = 2'd3; do_sweep("rand_lat0", 1'b0, 0, -1, 1'b0);

    sel = 1'b1; #1;
    mode = 2'd0; do_sweep("exact_lat2", 1'b0, 2, -1, 1'b0);
    mode = 2'd3; do_sweep("rand_lat2", 1'b0, 2, -1, 1'b0);
    mode = 2'd2; do_sweep("lsb_lat2", 1'b0, 2, -1, 1'b0);
    sel = 1'b0; #1;

    // Reset in the middle of a sweep
    mode = 2'd1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (101) @(negedge clk);
    check("mid_pair100", {56'd0, op_a0, op_b0}, 64'h64);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_outputs", {29'd0, op_a0, op_b0, busy0, done0, vld0, err0, sum0, max0}, 64'd0);
    seen_done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done0 === 1'b1 || busy0 === 1'b1) seen_done++;
    end
    check("rst_no_done", 64'(seen_done), 64'd0);
    do_sweep("zero_after_rst", 1'b0, 0, -1, 1'b0);
    check("zero_after_rst spec", {39'd0, err0, sum0, max0}, {39'd0, 9'd225, 16'd14400, 8'd225});

    // Stray start while busy, then back-to-back restart from DONE
    mode = 2'd3; do_sweep("glitch_start", 1'b0, 0, 50, 1'b1);
    mode = 2'd1; do_sweep("back_to_back", 1'b1, 0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
